// File: rtl/gpr_exec_pkg.sv
`timescale 1ns/1ps
// gpr_exec_pkg
//   Shared definitions for the gpr_exec_unit execute/write-back block:
//   opcode values, instruction field layout, flag bit indices and a small
//   opcode legality helper.
//   Optional build macro used by the unit: GPR_EXEC_BYPASS_EN.
package gpr_exec_pkg;

    // Opcodes (5-bit oper_type field); 12..31 are illegal.
    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_ROR     = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

    // rsrc2 overlays the top bits of the 16-bit immediate field.
    localparam int IR_RSRC2_LSB = 11;

    // Flag vector layout: {sign, zero, carry, overflow}.
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Instruction word: [31:27] oper_type, [26:22] rdst, [21:17] rsrc1,
    // [16] imm_mode, [15:0] isrc (rsrc2 = isrc[15:11]).
    typedef struct packed {
        logic [4:0]  oper_type;
        logic [4:0]  rdst;
        logic [4:0]  rsrc1;
        logic        imm_mode;
        logic [15:0] isrc;
    } instr_t;

    function automatic logic is_legal(input logic [4:0] op);
        return op <= OP_NOT;
    endfunction

endpackage

// File: rtl/gpr_exec_alu.sv
`timescale 1ns/1ps
// gpr_exec_alu
//   Purely combinational ALU for gpr_exec_unit.
//   Ports:
//     op        in   5       opcode
//     op1, op2  in   DATA_W  resolved operands (op1 carries SGPR for movsgpr)
//     result    out  DATA_W  value written to rdst
//     hi        out  DATA_W  high half of the product (mul only)
//     flags_out out  4       {sign, zero, carry, overflow} for this op
module gpr_exec_alu
    import gpr_exec_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [4:0]        op,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] hi,
    output logic [3:0]        flags_out
);
    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] W_VAL = DATA_W'(DATA_W);

    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   amt;
    logic                carry;
    logic                ovf;

    assign sum  = {1'b0, op1} + {1'b0, op2};
    // The extra top bit of an unsigned subtraction is the borrow.
    assign diff = {1'b0, op1} - {1'b0, op2};
    assign prod = {{DATA_W{1'b0}}, op1} * {{DATA_W{1'b0}}, op2};
    assign amt  = op2 % W_VAL;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it holding a value (inferred latch).
    always_comb begin
        result    = '0;
        hi        = '0;
        carry     = 1'b0;
        ovf       = 1'b0;
        flags_out = '0;
        case (op)
            OP_MOVSGPR: result = op1;
            OP_MOV:     result = op2;
            OP_ADD: begin
                result = sum[MSB:0];
                carry  = sum[DATA_W];
                ovf    = (op1[MSB] == op2[MSB]) && (sum[MSB] != op1[MSB]);
            end
            OP_SUB: begin
                result = diff[MSB:0];
                carry  = diff[DATA_W];
                ovf    = (op1[MSB] != op2[MSB]) && (diff[MSB] != op1[MSB]);
            end
            OP_MUL: begin
                result = prod[MSB:0];
                hi     = prod[2*DATA_W-1:DATA_W];
            end
            // A shift by DATA_W yields zero, so amt == 0 passes op1 through.
            OP_ROR:  result = (op1 >> amt) | (op1 << (W_VAL - amt));
            OP_AND:  result = op1 & op2;
            OP_XOR:  result = op1 ^ op2;
            OP_XNOR: result = ~(op1 ^ op2);
            OP_NAND: result = ~(op1 & op2);
            OP_NOR:  result = ~(op1 | op2);
            OP_NOT:  result = ~op1;
            default: result = '0;
        endcase

        // Multiply reports sign/zero of the full double-width product.
        if (op == OP_MUL) begin
            flags_out[FLAG_S] = prod[2*DATA_W-1];
            flags_out[FLAG_Z] = (prod == '0);
        end else begin
            flags_out[FLAG_S] = result[MSB];
            flags_out[FLAG_Z] = (result == '0);
        end
        flags_out[FLAG_C] = carry;
        flags_out[FLAG_V] = ovf;
    end

endmodule

// File: rtl/gpr_exec_unit.sv
`timescale 1ns/1ps
// gpr_exec_unit
//   Two-stage (accept, execute/write-back) unit with its own register file
//   and SGPR holding the multiply high half.
//   Ports:
//     clk, sys_rst_n   clock, synchronous active-low reset
//     in_valid/in_ready/in_ir   instruction handshake and 32-bit word
//     wb_valid/wb_addr/wb_data  register write happening at the next edge
//     flags            registered {sign, zero, carry, overflow}
//     err_illegal      pulse while an illegal opcode retires
//     dbg_addr/dbg_data combinational GPR read port
//   Build macro: GPR_EXEC_BYPASS_EN -- forward E results to dependent
//   operands instead of stalling for one cycle.
module gpr_exec_unit
    import gpr_exec_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_REGS   = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_ir,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        flags,
    output logic              err_illegal,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] MUL_LAST = 2'(MUL_CYCLES - 1);

    // Architectural state
    logic [DATA_W-1:0] gpr [NUM_REGS];
    logic [DATA_W-1:0] sgpr;
    logic [3:0]        flags_q;

    // E stage
    logic              e_valid;
    logic [4:0]        e_op;
    logic [AW-1:0]     e_rdst;
    logic [DATA_W-1:0] e_op1;
    logic [DATA_W-1:0] e_op2;
    logic [1:0]        e_cnt;   // mul: counts MUL_CYCLES-1 down to 0

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] alu_hi;
    logic [3:0]        alu_flags;

    instr_t            ir;
    logic [AW-1:0]     rs1, rs2, rd;
    logic              e_wb, e_mul_busy;
    logic              raw1, raw2, raw_sgpr;
    logic [DATA_W-1:0] src1, src2, sgpr_src;
    logic [DATA_W-1:0] op1_sel, op2_sel;
    logic              accept;

    assign ir  = in_ir;
    assign rs1 = ir.rsrc1[AW-1:0];
    assign rs2 = ir.isrc[IR_RSRC2_LSB +: AW];
    assign rd  = ir.rdst[AW-1:0];

    gpr_exec_alu #(.DATA_W(DATA_W)) u_alu (
        .op       (e_op),
        .op1      (e_op1),
        .op2      (e_op2),
        .result   (alu_res),
        .hi       (alu_hi),
        .flags_out(alu_flags)
    );

    assign e_wb       = e_valid && is_legal(e_op) && (e_cnt == '0);
    assign e_mul_busy = e_valid && (e_op == OP_MUL) && (e_cnt != '0);

    // Read-after-write against the value E writes at the coming edge.
    assign raw1     = e_wb && (rs1 == e_rdst);
    assign raw2     = e_wb && !ir.imm_mode && (rs2 == e_rdst);
    assign raw_sgpr = e_wb && (e_op == OP_MUL) && (ir.oper_type == OP_MOVSGPR);

`ifdef GPR_EXEC_BYPASS_EN
    assign src1     = raw1     ? alu_res : gpr[rs1];
    assign src2     = raw2     ? alu_res : gpr[rs2];
    assign sgpr_src = raw_sgpr ? alu_hi  : sgpr;
    assign in_ready = sys_rst_n && !e_mul_busy;
`else
    assign src1     = gpr[rs1];
    assign src2     = gpr[rs2];
    assign sgpr_src = sgpr;
    // One bubble lets the write land before the operand is read.
    assign in_ready = sys_rst_n && !e_mul_busy && !(raw1 || raw2 || raw_sgpr);
`endif

    // movsgpr routes SGPR through op1 so the ALU needs no extra input.
    assign op1_sel = (ir.oper_type == OP_MOVSGPR) ? sgpr_src : src1;
    assign op2_sel = ir.imm_mode ? DATA_W'(ir.isrc) : src2;
    assign accept  = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            e_valid <= 1'b0;
            e_op    <= OP_MOVSGPR;
            e_rdst  <= '0;
            e_op1   <= '0;
            e_op2   <= '0;
            e_cnt   <= '0;
            sgpr    <= '0;
            flags_q <= '0;
            // NOTE: the register file is architecturally cleared by reset, so
            // it is reset here rather than left as an unreset RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            if (e_wb) begin
                gpr[e_rdst] <= alu_res;
                flags_q     <= alu_flags;
                if (e_op == OP_MUL) begin
                    sgpr <= alu_hi;
                end
            end

            if (accept) begin
                e_valid <= 1'b1;
                e_op    <= ir.oper_type;
                e_rdst  <= rd;
                e_op1   <= op1_sel;
                e_op2   <= op2_sel;
                e_cnt   <= (ir.oper_type == OP_MUL) ? MUL_LAST : 2'd0;
            end else if (e_mul_busy) begin
                e_cnt <= e_cnt - 2'd1;
            end else begin
                e_valid <= 1'b0;
            end
        end
    end

    assign wb_valid    = e_wb;
    assign wb_addr     = 5'(e_rdst);
    assign wb_data     = alu_res;
    assign err_illegal = e_valid && !is_legal(e_op);
    assign flags       = flags_q;
    assign dbg_data    = gpr[dbg_addr[AW-1:0]];

endmodule

// File: tb/tb_gpr_exec_unit.sv
`timescale 1ns/1ps
// tb_gpr_exec_unit
//   Scoreboard bench for gpr_exec_unit. The driver runs an architectural
//   model at accept time and queues the expected retire; a negedge monitor
//   pops and compares whenever the unit retires.
module tb_gpr_exec_unit;

    localparam int DW = 16;
    localparam int NR = 32;
    localparam int MC = 2;
    localparam longint unsigned MASK = (64'd1 << DW) - 1;
    localparam longint unsigned HALF = 64'd1 << (DW - 1);
`ifdef GPR_EXEC_BYPASS_EN
    localparam int RAW_STALL = 0;
`else
    localparam int RAW_STALL = 1;
`endif

    logic          clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_ir = '0;
    logic          in_ready;
    logic          wb_valid;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic [3:0]    flags;
    logic          err_illegal;
    logic [4:0]    dbg_addr = '0;
    logic [DW-1:0] dbg_data;

    always #5 clk = ~clk;

    gpr_exec_unit #(.DATA_W(DW), .NUM_REGS(NR), .MUL_CYCLES(MC)) dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ir      (in_ir),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flags      (flags),
        .err_illegal(err_illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    typedef struct {
        bit              illegal;
        int unsigned     addr;
        longint unsigned data;
        bit [3:0]        flags;
    } exp_t;

    exp_t            sb[$];
    longint unsigned m_regs[NR];
    longint unsigned m_sgpr;
    bit [3:0]        m_flags;
    int              checks = 0;
    int              failures = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sval(longint unsigned x);
        return (x >= HALF) ? longint'(x) - longint'(64'd1 << DW) : longint'(x);
    endfunction

    function automatic void model_reset();
        foreach (m_regs[i]) m_regs[i] = 0;
        m_sgpr  = 0;
        m_flags = '0;
    endfunction

    // Architectural model: executes one instruction in program order.
    function automatic void model_exec(logic [31:0] ir);
        int unsigned     op, rd, rs1, rs2;
        longint unsigned a, b, r, p;
        longint          s;
        bit              c, v, sg, z;
        exp_t            e;
        op  = ir[31:27];
        rd  = ir[26:22] % NR;
        rs1 = ir[21:17] % NR;
        rs2 = ir[15:11] % NR;
        a   = m_regs[rs1];
        b   = ir[16] ? (longint'(ir[15:0]) & MASK) : m_regs[rs2];
        c = 0; v = 0; p = 0; r = 0;
        if (op > 11) begin
            e.illegal = 1; e.addr = 0; e.data = 0; e.flags = m_flags;
            sb.push_back(e);
            return;
        end
        case (op)
            0: r = m_sgpr;
            1: r = b;
            2: begin
                r = (a + b) & MASK;
                c = (a + b) > MASK;
                s = sval(a) + sval(b);
                v = (s > longint'(HALF) - 1) || (s < -longint'(HALF));
            end
            3: begin
                r = (a - b) & MASK;
                c = a < b;
                s = sval(a) - sval(b);
                v = (s > longint'(HALF) - 1) || (s < -longint'(HALF));
            end
            4: begin
                p = a * b;
                r = p & MASK;
                m_sgpr = p >> DW;
            end
            5: begin
                r = a;
                repeat (b % DW) r = ((r & 1) << (DW - 1)) | (r >> 1);
            end
            6:  r = a & b;
            7:  r = a ^ b;
            8:  r = ~(a ^ b) & MASK;
            9:  r = ~(a & b) & MASK;
            10: r = ~(a | b) & MASK;
            default: r = ~a & MASK;
        endcase
        m_regs[rd] = r;
        if (op == 4) begin
            sg = ((p >> (2 * DW - 1)) & 1) != 0;
            z  = (p == 0);
        end else begin
            sg = ((r >> (DW - 1)) & 1) != 0;
            z  = (r == 0);
        end
        m_flags   = {sg, z, c, v};
        e.illegal = 0; e.addr = rd; e.data = r; e.flags = m_flags;
        sb.push_back(e);
    endfunction

    function automatic logic [31:0] mk(int op, int rd, int rs1, bit imm, int low);
        logic [31:0] w;
        w[31:27] = op[4:0];
        w[26:22] = rd[4:0];
        w[21:17] = rs1[4:0];
        w[16]    = imm;
        w[15:0]  = low[15:0];
        return w;
    endfunction

    // ---------------- monitor ----------------
    exp_t     mon_e;
    bit       flag_pending = 0;
    bit [3:0] flag_exp;

    always @(negedge clk) begin
        if (!sys_rst_n) begin
            flag_pending = 0;
        end else begin
            if (flag_pending) begin
                check("flags_after_retire", flags, flag_exp);
                flag_pending = 0;
            end
            if (wb_valid || err_illegal) begin
                if (sb.size() == 0) begin
                    check("unexpected_retire", {wb_valid, err_illegal}, 2'b00);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.illegal) begin
                        check("err_illegal", err_illegal, 1);
                        check("wb_valid_on_illegal", wb_valid, 0);
                    end else begin
                        check("wb_valid", wb_valid, 1);
                        check("err_illegal_on_legal", err_illegal, 0);
                        check("wb_addr", wb_addr, mon_e.addr);
                        check("wb_data", wb_data, mon_e.data);
                    end
                    flag_exp     = mon_e.flags;
                    flag_pending = 1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(logic [31:0] ir, output int stalls);
        bit done;
        stalls = 0;
        done   = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_ir    = ir;
        while (!done) begin
            #4;
            if (in_ready) begin
                model_exec(ir);
                @(posedge clk);
                done = 1;
            end else begin
                stalls++;
                if (stalls > 20) begin
                    check("issue_timeout", stalls, 0);
                    in_valid = 1'b0;
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        idle(1);
        while (sb.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        idle(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("in_ready_during_reset", in_ready, 0);
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", in_ready, 1);
        check("wb_valid_after_reset", wb_valid, 0);
        check("err_illegal_after_reset", err_illegal, 0);
        check("flags_after_reset", flags, 4'b0000);
    endtask

    task automatic read_gpr(int r, output logic [DW-1:0] v);
        dbg_addr = r[4:0];
        #1;
        v = dbg_data;
    endtask

    task automatic check_regs();
        logic [DW-1:0] v;
        for (int r = 0; r < NR; r++) begin
            read_gpr(r, v);
            check($sformatf("dbg_gpr%0d", r), v, m_regs[r]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            s;
        logic [DW-1:0] v;
        logic [3:0]    f_before;

        model_reset();
        do_reset();

        // mov imm then add imm; result visible the cycle after accept
        issue(mk(1, 2, 0, 1, 2), s);
        issue(mk(2, 0, 2, 1, 4), s);
        #1;
        check("add_latency_wb_valid", wb_valid, 1);
        check("add_latency_wb_data", wb_data, 6);
        drain();
        read_gpr(0, v);
        check("gpr0_eq_6", v, 6);
        check("flags_add_small", flags, 4'b0000);

        // add 0xFFFF + 1 wraps to zero with carry
        issue(mk(1, 5, 0, 1, 16'hFFFF), s);
        issue(mk(2, 6, 5, 1, 1), s);
        drain();
        read_gpr(6, v);
        check("add_wrap_result", v, 0);
        check("flags_add_wrap", flags, 4'b0110);

        // sub 0x8000 - 1 overflows
        issue(mk(1, 7, 0, 1, 16'h8000), s);
        issue(mk(3, 8, 7, 1, 1), s);
        drain();
        read_gpr(8, v);
        check("sub_ovf_result", v, 16'h7FFF);
        check("flags_sub_ovf", flags, 4'b0001);

        // back-to-back RAW in register mode
        issue(mk(1, 3, 0, 1, 5), s);
        check("raw_mov_stall", s, 0);
        issue(mk(2, 4, 3, 0, 3 << 11), s);
        check("raw_add_stall", s, RAW_STALL);
        drain();
        read_gpr(4, v);
        check("raw_add_result", v, 10);

        // multi-cycle mul then movsgpr
        issue(mk(1, 9, 0, 1, 16'h1234), s);
        issue(mk(1, 10, 0, 1, 16'h0100), s);
        drain();
        issue(mk(4, 11, 9, 0, 10 << 11), s);
        issue(mk(1, 13, 0, 1, 1), s);
        check("mul_backpressure_cycles", s, MC - 1);
        issue(mk(0, 12, 0, 1, 0), s);
        drain();
        read_gpr(11, v);
        check("mul_low", v, 16'h3400);
        read_gpr(12, v);
        check("movsgpr_high", v, 16'h0012);

        // illegal opcode, then a normal add
        f_before = flags;
        issue(mk(20, 15, 1, 0, 2 << 11), s);
        #1;
        check("illegal_pulse", err_illegal, 1);
        check("illegal_no_wb", wb_valid, 0);
        issue(mk(2, 16, 2, 1, 3), s);
        #1;
        check("flags_kept_by_illegal", flags, f_before);
        drain();
        read_gpr(16, v);
        check("add_after_illegal", v, 5);
        check_regs();

        // reset during the first cycle of a mul aborts it
        issue(mk(4, 14, 9, 0, 10 << 11), s);
        do_reset();
        check_regs();
        issue(mk(0, 1, 0, 1, 0), s);
        drain();
        read_gpr(1, v);
        check("sgpr_cleared_by_reset", v, 0);

        // randomized instruction stream
        for (int i = 0; i < 1500; i++) begin
            int op, low;
            bit imm;
            op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 31))
                                              : int'($urandom_range(0, 11));
            imm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       low = 0;
                1:       low = 16'hFFFF;
                2:       low = 16'h8000;
                3:       low = 16'h7FFF;
                default: low = int'($urandom & 32'hFFFF);
            endcase
            if (!imm) low = (low & 16'h07FF) | (int'($urandom_range(0, 7)) << 11);
            issue(mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), imm, low), s);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();
        check_regs();
        check("final_flags", flags, m_flags);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
